// File: rtl/fill_cache_burst_pkg.sv
// Shared types and constants for the tile cache filler.
// Holds the fill state enum and the pixel packing helpers that turn a pixel
// width into pixels-per-word (PPW) and bytes-per-pixel (BPP).
package video_in_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_REQ    = 3'd2,
    ST_UNPACK = 3'd3,
    ST_DONE   = 3'd4
  } fill_state_t;

  // Default pixel width; instances with another DATA_SIZE use the helpers.
  localparam int DATA_SIZE_DEF = 8;

  // Pixels carried by one 32-bit bus word.
  function automatic int ppw_of(input int data_size);
    return 32'sd32 / data_size;
  endfunction

  // Bytes occupied by one pixel in external memory.
  function automatic int bpp_of(input int data_size);
    return data_size / 32'sd8;
  endfunction

  localparam int PPW = 32 / DATA_SIZE_DEF;
  localparam int BPP = DATA_SIZE_DEF / 8;

endpackage

// File: rtl/fill_cache_burst_if.sv
// Wishbone read port of the tile cache filler.
// master: the filler (drives STB/CYC/ADR/SEL/WE/LOCK, receives DAT/ACK/ERR).
// slave : the memory side.
interface fill_cache_burst_if;
  logic [31:0] p_wb_DAT_I;
  logic        p_wb_ACK_I;
  logic        p_wb_ERR_I;
  logic        p_wb_STB_O;
  logic        p_wb_CYC_O;
  logic        p_wb_LOCK_O;
  logic [3:0]  p_wb_SEL_O;
  logic        p_wb_WE_O;
  logic [31:0] p_wb_ADR_O;

  modport master (
    input  p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I,
    output p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_SEL_O, p_wb_WE_O, p_wb_ADR_O
  );

  modport slave (
    output p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I,
    input  p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_SEL_O, p_wb_WE_O, p_wb_ADR_O
  );
endinterface

// File: rtl/fill_cache_burst_pixel_unpack.sv
// Lane selector: picks pixel number `lane` out of a captured 32-bit word.
// Lanes are little-endian, lane 0 sits in the least significant bits.
// Ports: word (captured bus word), lane (lane index), pixel (selected pixel).
module pixel_unpack #(
  parameter int DATA_SIZE = 8,
  parameter int LANE_W    = 2
) (
  input  logic [31:0]          word,
  input  logic [LANE_W-1:0]    lane,
  output logic [DATA_SIZE-1:0] pixel
);
  assign pixel = word[DATA_SIZE*lane +: DATA_SIZE];
endmodule

// File: rtl/fill_cache_burst.sv
// Tile cache filler: copies a cache_w x cache_h pixel window starting at
// (pixel_c, pixel_l) of a frame in external RAM into the tile RAM.
// Ports: clk/nRST; window geometry and frame base (sampled while idle); go
// starts a fill; busy/cache_ready/err report progress; wb is the Wishbone
// read master; pixel_out/addr/w_e write the tile RAM at {row, col}.
module fill_cache_burst
  import video_in_pkg::*;
#(
  parameter int ADDR_SIZE_W = 5,
  parameter int ADDR_SIZE_H = 5,
  parameter int DATA_SIZE   = 8
) (
  input  logic                               clk,
  input  logic                               nRST,
  input  logic [9:0]                         pixel_c_I,
  input  logic [9:0]                         pixel_l_I,
  input  logic [ADDR_SIZE_W:0]               cache_w_I,
  input  logic [ADDR_SIZE_H:0]               cache_h_I,
  input  logic [10:0]                        im_width_I,
  input  logic [31:0]                        im_addr_I,
  input  logic                               go,
  output logic                               busy,
  output logic                               cache_ready,
  output logic                               err,
  fill_cache_burst_if.master                 wb,
  output logic [DATA_SIZE-1:0]               pixel_out,
  output logic [ADDR_SIZE_W+ADDR_SIZE_H-1:0] addr,
  output logic                               w_e
);
  localparam int WORD_PPW  = ppw_of(DATA_SIZE);
  localparam int PIX_BPP   = bpp_of(DATA_SIZE);
  localparam int LW        = (WORD_PPW > 1) ? $clog2(WORD_PPW) : 1;
  localparam int BPP_SHIFT = (PIX_BPP == 2) ? 1 : 0;
  localparam logic [LW-1:0] LANE_MAX = LW'(WORD_PPW - 1);

  fill_state_t state_r, next_state_s;

  logic [9:0]             pixel_c_r, pixel_l_r;
  logic [ADDR_SIZE_W:0]   cache_w_r;
  logic [ADDR_SIZE_H:0]   cache_h_r;
  logic [10:0]            im_width_r;
  logic [31:0]            im_addr_r;

  logic [31:0]            row_base_r, cur_byte_r, word_r;
  logic [ADDR_SIZE_W-1:0] col_r;
  logic [ADDR_SIZE_H-1:0] row_r;
  logic [LW-1:0]          lane_r;
  logic                   err_flag_r;

  logic [31:0]            nxt_row_base_s, nxt_cur_byte_s, nxt_word_s;
  logic [ADDR_SIZE_W-1:0] nxt_col_s;
  logic [ADDR_SIZE_H-1:0] nxt_row_s;
  logic [LW-1:0]          nxt_lane_s;
  logic                   nxt_err_flag_s;

  logic                   stb_s, busy_s, ready_s, err_s, we_s;
  logic [31:0]            adr_s;
  logic [DATA_SIZE-1:0]   unpack_pix_s;
  logic                   stb_r;

  // Window start offset: the single multiply, done once per fill.
  logic [20:0] lin_prod_s;
  logic [31:0] lin_pix_s, setup_base_s, row_stride_s, next_row_s;
  assign lin_prod_s   = 21'(pixel_l_r) * 21'(im_width_r);
  assign lin_pix_s    = {11'd0, lin_prod_s} + {22'd0, pixel_c_r};
  assign setup_base_s = im_addr_r + (lin_pix_s << BPP_SHIFT);
  assign row_stride_s = {21'd0, im_width_r} << BPP_SHIFT;
  assign next_row_s   = row_base_r + row_stride_s;

  // Last-pixel tests in ADDR_SIZE+1 bits so a full-size window matches the
  // counter value just before it wraps.
  logic [ADDR_SIZE_W:0] cw_m1_s;
  logic [ADDR_SIZE_H:0] ch_m1_s;
  logic last_col_s, last_row_s, last_lane_s, empty_s;
  logic [LW-1:0] start_lane_s;
  assign cw_m1_s      = cache_w_r - {{ADDR_SIZE_W{1'b0}}, 1'b1};
  assign ch_m1_s      = cache_h_r - {{ADDR_SIZE_H{1'b0}}, 1'b1};
  assign last_col_s   = ({1'b0, col_r} == cw_m1_s);
  assign last_row_s   = ({1'b0, row_r} == ch_m1_s);
  assign last_lane_s  = (lane_r == LANE_MAX);
  assign empty_s      = (cache_w_r == '0) || (cache_h_r == '0);
  assign start_lane_s = LW'(cur_byte_r[1:0] >> BPP_SHIFT);

  pixel_unpack #(.DATA_SIZE(DATA_SIZE), .LANE_W(LW)) u_unpack (
    .word  (word_r),
    .lane  (lane_r),
    .pixel (unpack_pix_s)
  );

  // State register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state_r <= ST_IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic; ERR takes priority over ACK.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   if (go) next_state_s = ST_SETUP; else next_state_s = ST_IDLE;
      ST_SETUP:  if (empty_s) next_state_s = ST_DONE; else next_state_s = ST_REQ;
      ST_REQ: begin
        if (wb.p_wb_ERR_I)      next_state_s = ST_DONE;
        else if (wb.p_wb_ACK_I) next_state_s = ST_UNPACK;
        else                    next_state_s = ST_REQ;
      end
      ST_UNPACK: begin
        if (last_col_s) begin
          if (last_row_s) next_state_s = ST_DONE;
          else            next_state_s = ST_REQ;
        end else if (last_lane_s) next_state_s = ST_REQ;
        else                      next_state_s = ST_UNPACK;
      end
      ST_DONE:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Window parameters track the inputs while idle and freeze during a fill.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pixel_c_r  <= 10'd0;
      pixel_l_r  <= 10'd0;
      cache_w_r  <= '0;
      cache_h_r  <= '0;
      im_width_r <= 11'd0;
      im_addr_r  <= 32'd0;
    end else if (state_r == ST_IDLE) begin
      pixel_c_r  <= pixel_c_I;
      pixel_l_r  <= pixel_l_I;
      cache_w_r  <= cache_w_I;
      cache_h_r  <= cache_h_I;
      im_width_r <= im_width_I;
      im_addr_r  <= im_addr_I;
    end else begin
      pixel_c_r  <= pixel_c_r;
      pixel_l_r  <= pixel_l_r;
      cache_w_r  <= cache_w_r;
      cache_h_r  <= cache_h_r;
      im_width_r <= im_width_r;
      im_addr_r  <= im_addr_r;
    end
  end

  // Address walk and counter updates. A new row always restarts from its own
  // base, so a word straddling a row end is fetched again for the next row.
  always_comb begin
    nxt_row_base_s = row_base_r;
    nxt_cur_byte_s = cur_byte_r;
    nxt_word_s     = word_r;
    nxt_col_s      = col_r;
    nxt_row_s      = row_r;
    nxt_lane_s     = lane_r;
    nxt_err_flag_s = err_flag_r;
    case (state_r)
      ST_SETUP: begin
        nxt_row_base_s = setup_base_s;
        nxt_cur_byte_s = setup_base_s;
        nxt_col_s      = '0;
        nxt_row_s      = '0;
        nxt_err_flag_s = 1'b0;
      end
      ST_REQ: begin
        if (wb.p_wb_ERR_I) begin
          nxt_err_flag_s = 1'b1;
        end else if (wb.p_wb_ACK_I) begin
          nxt_word_s = wb.p_wb_DAT_I;
          nxt_lane_s = start_lane_s;
        end else begin
          nxt_word_s = word_r;
        end
      end
      ST_UNPACK: begin
        if (last_col_s) begin
          if (!last_row_s) begin
            nxt_row_s      = row_r + 1'b1;
            nxt_col_s      = '0;
            nxt_row_base_s = next_row_s;
            nxt_cur_byte_s = next_row_s;
          end else begin
            nxt_row_s = row_r;
          end
        end else begin
          nxt_col_s = col_r + 1'b1;
          if (last_lane_s) nxt_cur_byte_s = {cur_byte_r[31:2] + 30'd1, 2'b00};
          else             nxt_lane_s     = lane_r + LW'(1);
        end
      end
      default: nxt_err_flag_s = err_flag_r;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      row_base_r <= 32'd0;
      cur_byte_r <= 32'd0;
      word_r     <= 32'd0;
      col_r      <= '0;
      row_r      <= '0;
      lane_r     <= '0;
      err_flag_r <= 1'b0;
    end else begin
      row_base_r <= nxt_row_base_s;
      cur_byte_r <= nxt_cur_byte_s;
      word_r     <= nxt_word_s;
      col_r      <= nxt_col_s;
      row_r      <= nxt_row_s;
      lane_r     <= nxt_lane_s;
      err_flag_r <= nxt_err_flag_s;
    end
  end

  // Output decode; bus strobe and busy look at the state being entered so the
  // registered copies line up with that state.
  always_comb begin
    stb_s   = (next_state_s == ST_REQ);
    adr_s   = {nxt_cur_byte_s[31:2], 2'b00};
    busy_s  = (next_state_s != ST_IDLE);
    ready_s = (state_r == ST_DONE);
    err_s   = (state_r == ST_DONE) && err_flag_r;
    we_s    = (state_r == ST_UNPACK);
  end

  // Output registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      stb_r       <= 1'b0;
      wb.p_wb_ADR_O <= 32'd0;
      busy        <= 1'b0;
      cache_ready <= 1'b0;
      err         <= 1'b0;
      w_e         <= 1'b0;
      addr        <= '0;
      pixel_out   <= '0;
    end else begin
      stb_r       <= stb_s;
      wb.p_wb_ADR_O <= adr_s;
      busy        <= busy_s;
      cache_ready <= ready_s;
      err         <= err_s;
      w_e         <= we_s;
      addr        <= {row_r, col_r};
      pixel_out   <= unpack_pix_s;
    end
  end

  assign wb.p_wb_STB_O  = stb_r;
  assign wb.p_wb_CYC_O  = stb_r;
  assign wb.p_wb_LOCK_O = 1'b0;
  assign wb.p_wb_SEL_O  = 4'hF;
  assign wb.p_wb_WE_O   = 1'b0;

endmodule

// File: tb/tb_fill_cache_burst.sv
// Bench for fill_cache_burst: an 8-bit and a 16-bit pixel instance share a
// zero-wait memory model; expected bus reads and tile writes are queued when
// a fill is started and compared as the DUTs produce them.
module tb_fill_cache_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nRST;
  logic [9:0]  pixel_c_i, pixel_l_i;
  logic [5:0]  cache_w_i, cache_h_i;
  logic [10:0] im_width_i;
  logic [31:0] im_addr_i;
  logic        go8, go16;

  logic busy8, ready8, err8, we8;
  logic [7:0] pix8;
  logic [9:0] addr8;
  logic busy16, ready16, err16, we16;
  logic [15:0] pix16;
  logic [9:0] addr16;

  fill_cache_burst_if bus8();
  fill_cache_burst_if bus16();

  fill_cache_burst #(.ADDR_SIZE_W(5), .ADDR_SIZE_H(5), .DATA_SIZE(8)) u_dut8 (
    .clk(clk), .nRST(nRST), .pixel_c_I(pixel_c_i), .pixel_l_I(pixel_l_i),
    .cache_w_I(cache_w_i), .cache_h_I(cache_h_i), .im_width_I(im_width_i),
    .im_addr_I(im_addr_i), .go(go8), .busy(busy8), .cache_ready(ready8),
    .err(err8), .wb(bus8), .pixel_out(pix8), .addr(addr8), .w_e(we8));

  fill_cache_burst #(.ADDR_SIZE_W(5), .ADDR_SIZE_H(5), .DATA_SIZE(16)) u_dut16 (
    .clk(clk), .nRST(nRST), .pixel_c_I(pixel_c_i), .pixel_l_I(pixel_l_i),
    .cache_w_I(cache_w_i), .cache_h_I(cache_h_i), .im_width_I(im_width_i),
    .im_addr_I(im_addr_i), .go(go16), .busy(busy16), .cache_ready(ready16),
    .err(err16), .wb(bus16), .pixel_out(pix16), .addr(addr16), .w_e(we16));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return {mem_byte(w + 32'd3), mem_byte(w + 32'd2), mem_byte(w + 32'd1), mem_byte(w)};
  endfunction

  // Memory model: ACK follows STB in the same cycle; ERR is added on the
  // selected transfer number (with ACK still high).
  int rd8 = 0, rd16 = 0;
  int err_at8 = -1;
  always_comb begin
    bus8.p_wb_DAT_I  = mem_word(bus8.p_wb_ADR_O);
    bus8.p_wb_ACK_I  = bus8.p_wb_STB_O;
    bus8.p_wb_ERR_I  = bus8.p_wb_STB_O && (rd8 == err_at8);
    bus16.p_wb_DAT_I = mem_word(bus16.p_wb_ADR_O);
    bus16.p_wb_ACK_I = bus16.p_wb_STB_O;
    bus16.p_wb_ERR_I = 1'b0;
  end

  // Transfer counters used to place the injected error.
  always @(posedge clk) begin
    if (bus8.p_wb_STB_O && (bus8.p_wb_ACK_I || bus8.p_wb_ERR_I)) rd8 <= rd8 + 1;
    if (bus16.p_wb_STB_O && bus16.p_wb_ACK_I) rd16 <= rd16 + 1;
  end

  logic [31:0] exp_rd8[$], exp_wr8[$], exp_rd16[$], exp_wr16[$];
  int extra8 = 0, extra16 = 0, ready_cnt8 = 0, ready_cnt16 = 0, stb_cnt8 = 0;
  logic err_pend8 = 1'b0;

  // Scoreboard side for the 8-bit instance.
  always @(negedge clk) begin
    if (err_pend8) check("stb8_drop_after_err", {30'd0, bus8.p_wb_STB_O, bus8.p_wb_CYC_O}, 32'd0);
    err_pend8 <= bus8.p_wb_STB_O && bus8.p_wb_ERR_I;
    if (bus8.p_wb_STB_O) begin
      stb_cnt8 <= stb_cnt8 + 1;
      if (bus8.p_wb_ACK_I || bus8.p_wb_ERR_I) begin
        if (exp_rd8.size() > 0) check("rd8_adr", bus8.p_wb_ADR_O, exp_rd8.pop_front());
        else extra8 <= extra8 + 1;
      end
    end
    if (we8) begin
      if (exp_wr8.size() > 0) check("wr8_addr_pix", {6'd0, addr8, 8'd0, pix8}, exp_wr8.pop_front());
      else extra8 <= extra8 + 1;
    end
    if (ready8) ready_cnt8 <= ready_cnt8 + 1;
  end

  // Scoreboard side for the 16-bit instance.
  always @(negedge clk) begin
    if (bus16.p_wb_STB_O && bus16.p_wb_ACK_I) begin
      if (exp_rd16.size() > 0) check("rd16_adr", bus16.p_wb_ADR_O, exp_rd16.pop_front());
      else extra16 <= extra16 + 1;
    end
    if (we16) begin
      if (exp_wr16.size() > 0) check("wr16_addr_pix", {6'd0, addr16, pix16}, exp_wr16.pop_front());
      else extra16 <= extra16 + 1;
    end
    if (ready16) ready_cnt16 <= ready_cnt16 + 1;
  end

  // Reference walk over the window in raster order: a read whenever the word
  // changes or a new row begins; stops after max_rd reads, writing pixels only
  // from the first ack_rd words.
  task automatic plan(input int ds, input int pc, input int pl, input int w, input int h,
                      input int width, input logic [31:0] base, input int max_rd, input int ack_rd);
    int bpp;
    int nrd;
    bit stop;
    logic [31:0] b, wd, last_wd;
    logic [15:0] px;
    bpp  = ds / 8;
    nrd  = 0;
    stop = 1'b0;
    for (int r = 0; r < h; r++) begin
      last_wd = 32'hFFFF_FFFF;
      for (int c = 0; c < w; c++) begin
        if (!stop) begin
          b  = base + 32'(((pl + r) * width + pc + c) * bpp);
          wd = {b[31:2], 2'b00};
          if (wd != last_wd) begin
            if (nrd >= ack_rd) begin
              if (nrd < max_rd) begin
                if (ds == 8) exp_rd8.push_back(wd); else exp_rd16.push_back(wd);
              end
              stop = 1'b1;
            end else begin
              if (ds == 8) exp_rd8.push_back(wd); else exp_rd16.push_back(wd);
              nrd++;
              last_wd = wd;
            end
          end
          if (!stop) begin
            px = (ds == 8) ? {8'd0, mem_byte(b)} : {mem_byte(b + 32'd1), mem_byte(b)};
            if (ds == 8) exp_wr8.push_back({6'd0, 10'(r * 32 + c), px});
            else         exp_wr16.push_back({6'd0, 10'(r * 32 + c), px});
          end
        end
      end
    end
  endtask

  task automatic run_fill(input bit sel16, input int pc, input int pl, input int w, input int h,
                          input int width, input logic [31:0] base, input int max_rd,
                          input int ack_rd, input logic exp_err, input int n_go);
    int rc0;
    bit seen;
    plan(sel16 ? 16 : 8, pc, pl, w, h, width, base, max_rd, ack_rd);
    @(negedge clk);
    pixel_c_i  = 10'(pc);
    pixel_l_i  = 10'(pl);
    cache_w_i  = 6'(w);
    cache_h_i  = 6'(h);
    im_width_i = 11'(width);
    im_addr_i  = base;
    rc0 = sel16 ? ready_cnt16 : ready_cnt8;
    go8  = !sel16;
    go16 = sel16;
    @(negedge clk);
    go8  = 1'b0;
    go16 = 1'b0;
    for (int k = 0; k < n_go; k++) begin
      @(negedge clk);
      go8  = !sel16;
      go16 = sel16;
      @(negedge clk);
      go8  = 1'b0;
      go16 = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (sel16 ? ready16 : ready8) begin
        seen = 1'b1;
        check("err_with_ready", {31'd0, sel16 ? err16 : err8}, {31'd0, exp_err});
      end
    end
    check("ready_seen", {31'd0, seen}, 32'd1);
    repeat (4) @(negedge clk);
    check("ready_pulses", 32'((sel16 ? ready_cnt16 : ready_cnt8) - rc0), 32'd1);
    check("reads_left", 32'(sel16 ? exp_rd16.size() : exp_rd8.size()), 32'd0);
    check("writes_left", 32'(sel16 ? exp_wr16.size() : exp_wr8.size()), 32'd0);
    check("extra_activity", 32'(sel16 ? extra16 : extra8), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst8_ctl", {24'd0, busy8, ready8, err8, we8, bus8.p_wb_STB_O, bus8.p_wb_CYC_O,
                       bus8.p_wb_LOCK_O, bus8.p_wb_WE_O}, 32'd0);
    check("rst8_adr", bus8.p_wb_ADR_O, 32'd0);
    check("rst8_wr", {14'd0, addr8, pix8}, 32'd0);
    check("rst8_sel", {28'd0, bus8.p_wb_SEL_O}, 32'h0000_000F);
    check("rst16_ctl", {24'd0, busy16, ready16, err16, we16, bus16.p_wb_STB_O,
                        bus16.p_wb_CYC_O, bus16.p_wb_LOCK_O, bus16.p_wb_WE_O}, 32'd0);
  endtask

  initial begin
    int stb0, ready_at, busy_n, rc0;
    bit seen;
    nRST = 1'b0; go8 = 1'b0; go16 = 1'b0;
    pixel_c_i = 10'd0; pixel_l_i = 10'd0; cache_w_i = 6'd0; cache_h_i = 6'd0;
    im_width_i = 11'd0; im_addr_i = 32'd0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    // 8x2 window, aligned start, two words per row.
    run_fill(1'b0, 4, 2, 8, 2, 640, 32'h0000_1000, 1000, 1000, 1'b0, 0);
    // Unaligned start: lane 3 of one word, lanes 0..2 of the next.
    run_fill(1'b0, 3, 0, 4, 1, 640, 32'h0000_1000, 1000, 1000, 1'b0, 0);
    // Row end in the middle of a word, 3x3 window with odd width.
    run_fill(1'b0, 6, 1, 3, 3, 37, 32'h0000_2001, 1000, 1000, 1'b0, 0);
    // 16-bit pixels starting on the upper half of a word.
    run_fill(1'b1, 1, 0, 3, 1, 100, 32'h0000_0000, 1000, 1000, 1'b0, 0);

    // Empty window: no bus traffic, ready three cycles after go.
    @(negedge clk);
    cache_w_i = 6'd0; cache_h_i = 6'd2;
    stb0 = stb_cnt8;
    go8 = 1'b1;
    @(negedge clk);
    go8 = 1'b0;
    ready_at = 0;
    busy_n = 0;
    for (int i = 1; i <= 6; i++) begin
      if (busy8) busy_n++;
      if (ready8 && ready_at == 0) ready_at = i;
      @(negedge clk);
    end
    check("empty_ready_cycle", 32'(ready_at), 32'd3);
    check("empty_busy_cycles", 32'(busy_n), 32'd2);
    check("empty_no_stb", 32'(stb_cnt8 - stb0), 32'd0);

    // Bus error on the second read of a 32x32 fill: four pixels only.
    err_at8 = rd8 + 1;
    run_fill(1'b0, 0, 0, 32, 32, 640, 32'h0000_0000, 2, 1, 1'b1, 0);
    err_at8 = -1;

    // Reset in the middle of unpacking.
    plan(8, 4, 2, 8, 2, 640, 32'h0000_1000, 1000, 1000);
    @(negedge clk);
    pixel_c_i = 10'd4; pixel_l_i = 10'd2; cache_w_i = 6'd8; cache_h_i = 6'd2;
    im_width_i = 11'd640; im_addr_i = 32'h0000_1000;
    rc0 = ready_cnt8;
    go8 = 1'b1;
    @(negedge clk);
    go8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (we8) seen = 1'b1;
    end
    check("unpack_reached", {31'd0, seen}, 32'd1);
    nRST = 1'b0;
    #1;
    check_reset_outputs();
    exp_rd8.delete();
    exp_wr8.delete();
    repeat (3) @(negedge clk);
    check("no_ready_on_reset", 32'(ready_cnt8 - rc0), 32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge clk);
    // Full fill after reset, with go pulsed repeatedly while busy.
    run_fill(1'b0, 4, 2, 8, 2, 640, 32'h0000_1000, 1000, 1000, 1'b0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fill_cache_burst.md
Name: fill_cache_burst

Overview:
- Parametrised successor of the tile cache filler, sitting between the Wishbone master port and the internal tile RAM of video_in.
- On go, copies a cache_w x cache_h pixel window starting at (pixel_c, pixel_l) of a frame in external RAM into the tile RAM.
- Reads 32-bit words, unpacks several pixels per word, and supports any pixel alignment.
- Image width and pixel size are generalised; bus errors are reported.

Parameters:
- ADDR_SIZE_W, 5, log2 of max cache width.
- ADDR_SIZE_H, 5, log2 of max cache height.
- DATA_SIZE, 8, pixel width in bits; legal values 8 or 16. PPW = 32/DATA_SIZE pixels per word; BPP = DATA_SIZE/8 bytes per pixel.

Ports:
- clk  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- pixel_c_I  in  10  window start column.
- pixel_l_I  in  10  window start line.
- cache_w_I  in  ADDR_SIZE_W+1  window width in pixels, 0..2**ADDR_SIZE_W.
- cache_h_I  in  ADDR_SIZE_H+1  window height in lines, 0..2**ADDR_SIZE_H.
- im_width_I  in  11  frame line length in pixels.
- im_addr_I  in  32  frame base byte address.
- go  in  1  start request, sampled in IDLE only.
- busy  out  1  high from go acceptance until cache_ready.
- cache_ready  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with cache_ready if the fill aborted.
- p_wb_DAT_I  in  32  read data.
- p_wb_ACK_I  in  1  acknowledge.
- p_wb_ERR_I  in  1  bus error.
- p_wb_STB_O, p_wb_CYC_O  out  1  strobe/cycle.
- p_wb_LOCK_O  out  1  constant 0.
- p_wb_SEL_O  out  4  constant 4'hF.
- p_wb_WE_O  out  1  constant 0.
- p_wb_ADR_O  out  32  word-aligned byte address (bits [1:0] = 0).
- pixel_out  out  DATA_SIZE  pixel to tile RAM.
- addr  out  ADDR_SIZE_W+ADDR_SIZE_H  tile RAM address = {row, col}.
- w_e  out  1  tile RAM write enable.

Behaviour:
- Reset state: all outputs 0 except SEL = 4'hF; state IDLE. A reset mid-fill drops STB/CYC immediately and no pulse is issued.
- State machine: IDLE -> SETUP -> REQ <-> UNPACK -> DONE -> IDLE.
- IDLE:
  - Inputs are registered every cycle.
  - go=1 moves to SETUP next cycle and sets busy.
  - go outside IDLE is ignored.
- SETUP (1 cycle):
  - row_base = im_addr + (pixel_l*im_width + pixel_c)*BPP, computed modulo 2**32. This is the only multiply.
  - If cache_w==0 or cache_h==0, go to DONE with no bus access.
- REQ:
  - STB=CYC=1; ADR = cur_byte & ~3.
  - Hold until ACK or ERR.
  - On ACK, capture DAT_I and go to UNPACK.
  - On ERR, drop STB/CYC and go to DONE with err flagged.
- UNPACK:
  - STB/CYC=0. One pixel per cycle with w_e=1.
  - Pixel k is DAT_I[DATA_SIZE*k +: DATA_SIZE] (little-endian lanes).
  - Start lane = cur_byte[1:0]/BPP. Emit lanes until lane PPW-1 or until col reaches cache_w-1.
  - After the last lane of a word with pixels remaining in the row: cur_byte advances to the next word, go to REQ.
  - At row end with row < cache_h-1: row+1, col=0, row_base += im_width*BPP (adder only), cur_byte = new row_base, go to REQ.
  - At the last pixel of the last row, go to DONE.
- DONE: cache_ready=1 (and err if flagged) for one cycle; busy drops; next state IDLE.
- Timing and counters:
  - Minimum cost per word is 1 REQ cycle + ACK wait + n UNPACK cycles.
  - Lanes before the start lane are discarded; a row never writes beyond cache_w.
  - A word straddling the end of a row is re-fetched for the next row; there is no cross-row reuse.
  - col and row counters are ADDR_SIZE_W and ADDR_SIZE_H bits wide. Full-size windows end exactly when the counters wrap; row/col comparisons use cache_w-1 and cache_h-1 in ADDR_SIZE+1 bits.
- Simultaneous ACK and ERR: ERR wins.

Decomposition:
- Package video_in_pkg holds the state enum fill_state_t and the localparams PPW and BPP derived from DATA_SIZE.
- One sub-module, pixel_unpack: combinational lane select from a captured word and a lane index, producing pixel_out.

Test Plan:
- DATA_SIZE=8, im_width=640, im_addr=0x1000, pixel_c=4, pixel_l=2, 8x2 window, zero-wait ACK:
  - Reads 0x1504, 0x1508, then 0x1784, 0x1788.
  - 16 writes, addr 0..7 and 32..39.
  - cache_ready pulses once, err=0.
- Unaligned start pixel_c=3, 4x1 window:
  - Reads 0x1000+(lane 3 only) then the next word (lanes 0..2).
  - pixel_out sequence equals bytes 3,4,5,6 of frame memory.
- DATA_SIZE=16, pixel_c=1, 3x1 window, im_addr=0:
  - Reads 0x0, 0x4.
  - pixel_out = upper half of word0, then both halves of word1.
- cache_w=0 with go:
  - No STB ever; cache_ready exactly 3 cycles after go; busy high 2 cycles.
- ERR_I asserted on the second read of a 32x32 fill:
  - STB/CYC drop the next cycle.
  - cache_ready and err pulse together.
  - Only 4 pixels are written.
- nRST low during UNPACK:
  - All outputs 0 asynchronously.
  - After release, go restarts a full fill correctly.
  - go pulses while busy have no effect.
